// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter
// Shares the one sdram_top request port between the write path (FIFO -> SDRAM)
// and the read path (SDRAM -> VGA FIFO), one 512-word row burst per grant.
// Frames alternate between two buffers. Readout follows the last completed
// buffer and restarts on every vertical sync pulse.
module sdram_frame_arbiter #(
    parameter int ROWS_PER_FRAME = 128,
    parameter int WR_THRESH      = 512,
    parameter int RD_THRESH      = 512
) (
    input  logic        clk_133M,
    input  logic        rst_133,
    input  logic        vsync_133,
    input  logic [10:0] wr_fifo_used,
    input  logic [10:0] rd_fifo_used,
    output logic        wr_sdram_req,
    input  logic        wr_sdram_ack,
    output logic [23:0] wr_sdram_add,
    output logic        rd_sdram_req,
    input  logic        rd_sdram_ack,
    output logic [23:0] rd_sdram_add,
    output logic        frame_valid,
    output logic [7:0]  frame_count,
    output logic        wr_stall
);

    localparam logic [10:0] WR_TH    = 11'(WR_THRESH);
    localparam logic [10:0] RD_TH    = 11'(RD_THRESH);
    // rd_row is one bit wider than wr_row so it can saturate at ROWS_PER_FRAME
    localparam logic [13:0] ROWS     = 14'(ROWS_PER_FRAME);
    localparam logic [12:0] LAST_ROW = 13'(ROWS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

    state_t      state;
    logic        wr_buf;
    logic        rd_buf;
    logic        done_buf;
    logic        last_wr;     // 1 = last grant went to write, 0 = read
    logic [12:0] wr_row;
    logic [13:0] rd_row;

    logic        rd_active;
    logic        collide;
    logic        wr_want;
    logic        wr_pend;
    logic        rd_pend;

    // Reader is mid-frame: a valid frame exists, outside sync, rows remain
    assign rd_active = frame_valid & vsync_133 & (rd_row < ROWS);
    // Writer must not overwrite the buffer currently being displayed
    assign collide   = (wr_buf == rd_buf) & rd_active;
    assign wr_want   = (wr_fifo_used >= WR_TH);
    assign wr_pend   = wr_want & ~collide;
    assign rd_pend   = rd_active & (rd_fifo_used <= RD_TH);
    assign wr_stall  = wr_want & collide;

    // Addresses follow the row/buffer registers, which only move on ack
    // (or, for the reader, during sync while not bursting)
    assign wr_sdram_add = {1'b0, wr_buf, wr_row, 9'd0};
    assign rd_sdram_add = {1'b0, rd_buf, rd_row[12:0], 9'd0};

    // Grant FSM with registered requests, row/buffer bookkeeping and vsync restart
    always_ff @(posedge clk_133M or negedge rst_133) begin
        if (!rst_133) begin
            state        <= IDLE;
            wr_sdram_req <= 1'b0;
            rd_sdram_req <= 1'b0;
            wr_buf       <= 1'b0;
            rd_buf       <= 1'b0;
            done_buf     <= 1'b0;
            last_wr      <= 1'b0;
            wr_row       <= '0;
            rd_row       <= '0;
            frame_valid  <= 1'b0;
            frame_count  <= '0;
        end else begin
            // A burst in flight is never aborted; outside it, sync rewinds the
            // reader onto the most recently completed buffer
            if (!vsync_133 && state != RD_BUSY) begin
                rd_row <= '0;
                rd_buf <= done_buf;
            end

            case (state)
                IDLE: begin
                    // On a tie the path that did not go last wins
                    if (wr_pend && (!rd_pend || !last_wr)) begin
                        state        <= WR_BUSY;
                        wr_sdram_req <= 1'b1;
                    end else if (rd_pend) begin
                        state        <= RD_BUSY;
                        rd_sdram_req <= 1'b1;
                    end
                end

                WR_BUSY: begin
                    if (wr_sdram_ack) begin
                        wr_sdram_req <= 1'b0;
                        last_wr      <= 1'b1;
                        state        <= IDLE;
                        if (wr_row == LAST_ROW) begin
                            wr_row      <= '0;
                            done_buf    <= wr_buf;
                            wr_buf      <= ~wr_buf;
                            frame_valid <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            wr_row <= wr_row + 13'd1;
                        end
                    end
                end

                RD_BUSY: begin
                    if (rd_sdram_ack) begin
                        rd_sdram_req <= 1'b0;
                        last_wr      <= 1'b0;
                        state        <= IDLE;
                        if (!vsync_133) begin
                            rd_row <= '0;
                        end else begin
                            rd_row <= rd_row + 14'd1;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    wr_sdram_req <= 1'b0;
                    rd_sdram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Testbench for sdram_frame_arbiter: vector table for idle-state gating,
// scripted multi-frame sequences, and an address scoreboard fed by the script
// and drained whenever a request rises.
module tb_sdram_frame_arbiter;

    localparam int ACK_DLY = 10;

    logic        clk_133M = 1'b0;
    logic        rst_133;
    logic        vsync_133;
    logic [10:0] wr_fifo_used;
    logic [10:0] rd_fifo_used;
    logic        wr_sdram_req;
    logic        wr_sdram_ack;
    logic [23:0] wr_sdram_add;
    logic        rd_sdram_req;
    logic        rd_sdram_ack;
    logic [23:0] rd_sdram_add;
    logic        frame_valid;
    logic [7:0]  frame_count;
    logic        wr_stall;

    sdram_frame_arbiter #(
        .ROWS_PER_FRAME(128),
        .WR_THRESH     (512),
        .RD_THRESH     (512)
    ) dut (
        .clk_133M    (clk_133M),
        .rst_133     (rst_133),
        .vsync_133   (vsync_133),
        .wr_fifo_used(wr_fifo_used),
        .rd_fifo_used(rd_fifo_used),
        .wr_sdram_req(wr_sdram_req),
        .wr_sdram_ack(wr_sdram_ack),
        .wr_sdram_add(wr_sdram_add),
        .rd_sdram_req(rd_sdram_req),
        .rd_sdram_ack(rd_sdram_ack),
        .rd_sdram_add(rd_sdram_add),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .wr_stall    (wr_stall)
    );

    always #4 clk_133M = ~clk_133M;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          wr_rises  = 0;
    int          rd_rises  = 0;
    bit          mon_en    = 1'b0;
    bit          wr_hold   = 1'b1;
    bit          rd_hold   = 1'b1;
    logic [23:0] wr_exp[$];
    logic [23:0] rd_exp[$];
    logic [23:0] wr_cur    = '0;
    logic [23:0] rd_cur    = '0;
    logic        prev_wr   = 1'b0;
    logic        prev_rd   = 1'b0;
    bit          grant_log[$];

    typedef struct {
        logic [10:0] wr_used;
        logic [10:0] rd_used;
        logic        vsync;
        logic        exp_wr_req;
        logic        exp_rd_req;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [6];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk_133M);
        #2;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_rises < target && n < budget) begin
            tick();
            n++;
        end
        chk("wr_request_count", 32'(wr_rises), 32'(target));
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_rises < target && n < budget) begin
            tick();
            n++;
        end
        chk("rd_request_count", 32'(rd_rises), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((wr_sdram_req || rd_sdram_req) && n < 100) begin
            tick();
            n++;
        end
        chk({"idle_", tag}, 32'({wr_sdram_req, rd_sdram_req}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_req"},      32'(wr_sdram_req), 32'd0);
        chk({tag, "_rd_req"},      32'(rd_sdram_req), 32'd0);
        chk({tag, "_wr_add"},      32'(wr_sdram_add), 32'd0);
        chk({tag, "_rd_add"},      32'(rd_sdram_add), 32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid),  32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count),  32'd0);
        chk({tag, "_wr_stall"},    32'(wr_stall),     32'd0);
    endtask

    // Write-side SDRAM model: ack ACK_DLY cycles after a request is seen
    initial begin
        wr_sdram_ack = 1'b0;
        forever begin
            @(negedge clk_133M);
            if (wr_sdram_req) begin
                repeat (ACK_DLY - 1) @(negedge clk_133M);
                while (wr_hold) @(negedge clk_133M);
                if (wr_sdram_req) begin
                    wr_sdram_ack = 1'b1;
                    @(negedge clk_133M);
                    wr_sdram_ack = 1'b0;
                end
            end
        end
    end

    // Read-side SDRAM model, same timing
    initial begin
        rd_sdram_ack = 1'b0;
        forever begin
            @(negedge clk_133M);
            if (rd_sdram_req) begin
                repeat (ACK_DLY - 1) @(negedge clk_133M);
                while (rd_hold) @(negedge clk_133M);
                if (rd_sdram_req) begin
                    rd_sdram_ack = 1'b1;
                    @(negedge clk_133M);
                    rd_sdram_ack = 1'b0;
                end
            end
        end
    end

    // Scoreboard: pop expected address on each request rise, hold it while req is up
    initial begin
        forever begin
            @(negedge clk_133M);
            if (mon_en) begin
                if (wr_sdram_req && !prev_wr) begin
                    wr_rises++;
                    grant_log.push_back(1'b1);
                    chk("idle_gap_before_wr", 32'(prev_rd), 32'd0);
                    if (wr_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wr_unexpected_req: got request at %06h, required none", wr_sdram_add);
                    end else begin
                        wr_cur = wr_exp.pop_front();
                    end
                end
                if (rd_sdram_req && !prev_rd) begin
                    rd_rises++;
                    grant_log.push_back(1'b0);
                    chk("idle_gap_before_rd", 32'(prev_wr), 32'd0);
                    if (rd_exp.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rd_unexpected_req: got request at %06h, required none", rd_sdram_add);
                    end else begin
                        rd_cur = rd_exp.pop_front();
                    end
                end
                if (wr_sdram_req) chk("wr_addr", 32'(wr_sdram_add), 32'(wr_cur));
                if (rd_sdram_req) chk("rd_addr", 32'(rd_sdram_add), 32'(rd_cur));
                chk("req_exclusive", 32'(wr_sdram_req & rd_sdram_req), 32'd0);
            end
            prev_wr = wr_sdram_req;
            prev_rd = rd_sdram_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{11'd0,    11'd0,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{11'd511,  11'd0,    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{11'd512,  11'd0,    1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{11'd2047, 11'd2047, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{11'd511,  11'd0,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{11'd1024, 11'd512,  1'b1, 1'b1, 1'b0, 1'b0};

        rst_133      = 1'b0;
        vsync_133    = 1'b1;
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd2047;
        repeat (2) tick();

        // Idle-state gating before any frame exists: reads never request
        for (int i = 0; i < 6; i++) begin
            rst_133      = 1'b0;
            wr_fifo_used = vecs[i].wr_used;
            rd_fifo_used = vecs[i].rd_used;
            vsync_133    = vecs[i].vsync;
            tick();
            check_reset_outputs($sformatf("vec%0d_reset", i));
            rst_133 = 1'b1;
            tick();
            tick();
            chk($sformatf("vec%0d_wr_req", i),   32'(wr_sdram_req), 32'(vecs[i].exp_wr_req));
            chk($sformatf("vec%0d_rd_req", i),   32'(rd_sdram_req), 32'(vecs[i].exp_rd_req));
            chk($sformatf("vec%0d_wr_stall", i), 32'(wr_stall),     32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_wr_add", i),   32'(wr_sdram_add), 32'd0);
        end

        // First frame: 128 writes into buffer 0, then first row of buffer 1
        rst_133      = 1'b0;
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd2047;
        vsync_133    = 1'b1;
        wr_hold      = 1'b0;
        rd_hold      = 1'b0;
        tick();
        mon_en  = 1'b1;
        rst_133 = 1'b1;
        tick();
        for (int r = 0; r < 128; r++) wr_exp.push_back(24'(r) << 9);
        wr_exp.push_back(24'h400000);
        wr_fifo_used = 11'd512;
        wait_wr(128, 3000);
        chk("frame_valid_before_last_ack", 32'(frame_valid), 32'd0);
        chk("frame_count_before_last_ack", 32'(frame_count), 32'd0);
        wait_wr(129, 100);
        wr_fifo_used = 11'd0;
        chk("frame_valid_after_frame1", 32'(frame_valid), 32'd1);
        chk("frame_count_after_frame1", 32'(frame_count), 32'd1);
        wait_idle("frame1");

        // Reader starts on buffer 0 and pauses at rd_row = 10
        for (int r = 0; r < 10; r++) rd_exp.push_back(24'(r) << 9);
        rd_fifo_used = 11'd0;
        wait_rd(10, 400);
        rd_fifo_used = 11'd2047;
        wait_idle("reads_0_9");

        // Writer finishes buffer 1 and wraps into buffer 0, which is on screen
        for (int r = 1; r < 128; r++) wr_exp.push_back(24'h400000 | (24'(r) << 9));
        wr_fifo_used = 11'd512;
        wait_wr(256, 3000);
        wait_idle("frame2");
        repeat (5) tick();
        chk("collide_wr_stall",    32'(wr_stall),     32'd1);
        chk("collide_no_wr_req",   32'(wr_sdram_req), 32'd0);
        chk("frame_count_frame2",  32'(frame_count),  32'd2);
        chk("collide_wr_add",      32'(wr_sdram_add), 32'd0);
        repeat (20) tick();
        chk("collide_still_no_req", 32'(wr_sdram_req), 32'd0);

        // Reader resumes rows 10..40; sync arrives during the row-40 burst
        for (int r = 10; r < 41; r++) rd_exp.push_back(24'(r) << 9);
        rd_fifo_used = 11'd0;
        wait_rd(41, 1000);
        rd_hold   = 1'b1;
        vsync_133 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("vsync_rd_req_held", 32'(rd_sdram_req), 32'd1);
            chk("vsync_rd_add_held", 32'(rd_sdram_add), 32'h005000);
            chk("vsync_no_stall",    32'(wr_stall),     32'd0);
        end
        wr_fifo_used = 11'd0;
        rd_hold      = 1'b0;
        wait_idle("vsync_burst");
        chk("vsync_row_cleared_on_ack", 32'(rd_sdram_add), 32'd0);
        tick();
        chk("vsync_rd_buf_reloaded", 32'(rd_sdram_add), 32'h400000);
        chk("vsync_no_rd_req",       32'(rd_sdram_req), 32'd0);
        tick();

        // Tie: both paths pending after sync, last grant was a read
        grant_log.delete();
        for (int r = 0; r < 3; r++) begin
            wr_exp.push_back(24'(r) << 9);
            rd_exp.push_back(24'h400000 | (24'(r) << 9));
        end
        vsync_133    = 1'b1;
        wr_fifo_used = 11'd512;
        begin
            int n = 0;
            while (grant_log.size() < 6 && n < 300) begin
                tick();
                n++;
            end
        end
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd2047;
        chk("tie_grant_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("tie_grant%0d_is_wr", i), 32'(grant_log[i]), 32'((i % 2) == 0));
        wait_idle("tie");

        // Reset while a write burst is outstanding
        wr_exp.push_back(24'h000600);
        wr_hold      = 1'b1;
        wr_fifo_used = 11'd512;
        wait_wr(260, 100);
        tick();
        chk("pre_reset_wr_req", 32'(wr_sdram_req), 32'd1);
        mon_en  = 1'b0;
        rst_133 = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wr_fifo_used = 11'd0;
        tick();
        check_reset_outputs("held_reset");
        rst_133 = 1'b1;
        repeat (3) tick();
        chk("post_reset_no_wr_req",    32'(wr_sdram_req), 32'd0);
        chk("post_reset_frame_valid",  32'(frame_valid),  32'd0);

        chk("wr_scoreboard_drained", 32'(wr_exp.size()), 32'd0);
        chk("rd_scoreboard_drained", 32'(rd_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
